multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

- Multi-cycle control FSM for the RV32I datapath.
- Sequences each instruction through fetch, decode, execute, memory and write-back.
- Handshakes with instruction and data memory and drives every datapath control input: ALU op, register write, mux selects, PC enable.
- Sits between the memories and the datapath; replaces the single-cycle combinational decoder.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- instr_code  input  32  instruction register contents (latched by ir_en)
- imem_req  output  1  instruction fetch request
- imem_ready  input  1  instruction valid on imem data this cycle
- ir_en  output  1  load instruction register
- dmem_req  output  1  data memory access request
- dmem_we  output  1  store when 1, load when 0
- dmem_size  output  3  funct3 of the load/store
- dmem_ready  input  1  data access complete; load data stable until next dmem_req
- pc_en  output  1  PC register update strobe
- alu_controls  output  4  ALU operation / branch condition
- reg_wr_en  output  1  register file write strobe
- aluSrcMux_sel  output  1  0 = rs2, 1 = immediate
- RegWdataSel  output  3  0 alu, 1 dRdata, 2 imm, 3 base+imm, 4 pc+4
- Branch, jal, jalr  output  1 each  PC-path selects
- instret  output  32  retired-instruction counter
- halted  output  1  sticky illegal-instruction halt

## Operation
**States:** FETCH, DECODE, EXECUTE, MEM, WB, TRAP.

- **FETCH**
  - imem_req=1.
  - On imem_ready: ir_en=1 for that cycle, next state DECODE.
  - imem_ready is ignored in every other state.
- **DECODE**
  - Lasts one cycle, then EXECUTE.
  - Selects and alu_controls become valid from the latched instr_code.
- **EXECUTE**
  - R/I-ALU, LUI, AUIPC: reg_wr_en=1, pc_en=1, next state FETCH.
    - RegWdataSel is 0 for R/I-ALU, 2 for LUI, 3 for AUIPC.
  - B-type: Branch=1, alu_controls={0,funct3}, pc_en=1, next state FETCH.
  - JAL: jal=1, reg_wr_en=1, RegWdataSel=4, pc_en=1, next state FETCH.
  - JALR: jal=1 and jalr=1, reg_wr_en=1, RegWdataSel=4, pc_en=1, next state FETCH.
  - Load/store: alu_controls=ADD, aluSrcMux_sel=1, next state MEM.
  - Unknown opcode: see Configuration.
- **MEM**
  - dmem_req=1; dmem_we=1 for stores.
  - Request is held until dmem_ready.
  - On dmem_ready, store: pc_en=1, next state FETCH.
  - On dmem_ready, load: next state WB.
- **WB**
  - reg_wr_en=1, RegWdataSel=1, pc_en=1, next state FETCH.
- **ALU decode**
  - R-type: alu_controls = {funct7[5], funct3}.
  - I-type: alu_controls = {funct7[5] only when funct3=101, funct3}.
  - All other instructions: ADD = 4'b0000.
- **instret**
  - Increments by 1 on every cycle with pc_en=1.
  - Wraps 0xFFFF_FFFF → 0.
- **Strobe discipline**
  - reg_wr_en, pc_en, ir_en, imem_req and dmem_req are asserted only in the cycles listed above, and are 0 everywhere else.
  - Selects hold their decoded value from DECODE through the end of the instruction.
  - All controls are 0 in FETCH.

## Timing
- Reset (reset_n low, any state):
  - state → FETCH, instret → 0, halted → 0.
  - All outputs are forced 0 while reset_n is low, including imem_req.
  - An outstanding memory request is abandoned.
- First imem_req is in the first clock after reset_n rises.
- Zero-wait latencies (imem_ready/dmem_ready high on the request cycle):
  - ALU/branch/jump: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds one.
- A ready in the same cycle as its request is accepted, which gives a single-cycle FETCH/MEM.
- pc_en and reg_wr_en coincide in one cycle per instruction. The write uses the pre-update PC; the PC and register file update on the same edge.
- The FSM and instret are registered. Strobes are decoded combinationally from the state and the latched instruction.

## Configuration
Macro: **ILLEGAL_INSTR_TRAP_EN**

- **Defined**
  - An unknown opcode in EXECUTE → TRAP.
  - In TRAP: halted=1 and all strobes are 0.
  - TRAP is left only by reset.
- **Undefined**
  - An unknown opcode executes as a NOP: pc_en=1, no writes, next state FETCH, instret increments.
  - halted is tied 0 and TRAP is not synthesized.

## Structure
- **Shared package:** `rv32i_ctrl_pkg`
  - State enum.
  - Opcode constants (R, I, IL, S, B, LUI, AUIPC, JAL, JALR).
  - ALU control encodings.
  - RegWdataSel encoding constants.
- **Sub-module:** `alu_decoder`
  - Combinational {opcode, funct3, funct7[5]} → alu_controls.
  - Instantiated once by multicycle_ctrl.

## Test plan
- **ADD:** `add x3,x1,x2` (0x002081B3), zero-wait → alu_controls=0000, reg_wr_en and pc_en both high only in cycle 3, instret=1.
- **Load with wait:** `lw x5,4(x0)` with dmem_ready delayed 2 cycles → dmem_req high 3 cycles with dmem_we=0, WB asserts RegWdataSel=1 and reg_wr_en, total 7 cycles.
- **Store then SRAI:** `sw x5,8(x0)`, then `srai x6,x5,3` (0x4032D313) → dmem_we=1 in MEM with no reg_wr_en; SRAI gives alu_controls=1101.
- **JALR:** `jalr x1,0(x2)` → jal=1, jalr=1, RegWdataSel=4, reg_wr_en=1, pc_en=1 in EXECUTE.
- **Reset mid-access:** reset_n pulsed low during MEM with dmem_req high → dmem_req drops immediately, instret=0, imem_req high in the first cycle after release.
- **Illegal opcode:** 0x0000007F → with ILLEGAL_INSTR_TRAP_EN, halted=1 and no further imem_req; without it, pc_en=1 and instret increments.

Source files
------------

// File: rtl/rv32i_ctrl_pkg.sv
// Shared constants for the RV32I multi-cycle controller: FSM state codes,
// opcodes, ALU control encodings and write-back select codes.
package rv32i_ctrl_pkg;

  localparam logic [2:0] ST_FETCH   = 3'd0;
  localparam logic [2:0] ST_DECODE  = 3'd1;
  localparam logic [2:0] ST_EXECUTE = 3'd2;
  localparam logic [2:0] ST_MEM     = 3'd3;
  localparam logic [2:0] ST_WB      = 3'd4;
  localparam logic [2:0] ST_TRAP    = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_IL    = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] WSEL_ALU   = 3'd0;
  localparam logic [2:0] WSEL_DMEM  = 3'd1;
  localparam logic [2:0] WSEL_IMM   = 3'd2;
  localparam logic [2:0] WSEL_PCIMM = 3'd3;
  localparam logic [2:0] WSEL_PC4   = 3'd4;

  typedef enum logic [3:0] {
    IC_ALU_R,
    IC_ALU_I,
    IC_LOAD,
    IC_STORE,
    IC_BRANCH,
    IC_LUI,
    IC_AUIPC,
    IC_JAL,
    IC_JALR,
    IC_ILLEGAL
  } instr_class_e;

  function automatic instr_class_e classify(input logic [6:0] opcode);
    instr_class_e c;
    case (opcode)
      OP_R:     c = IC_ALU_R;
      OP_I:     c = IC_ALU_I;
      OP_IL:    c = IC_LOAD;
      OP_S:     c = IC_STORE;
      OP_B:     c = IC_BRANCH;
      OP_LUI:   c = IC_LUI;
      OP_AUIPC: c = IC_AUIPC;
      OP_JAL:   c = IC_JAL;
      OP_JALR:  c = IC_JALR;
      default:  c = IC_ILLEGAL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-control decode from {opcode, funct3, funct7[5]}.
module alu_decoder
  import rv32i_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_controls
);

  always_comb begin
    alu_controls = ALU_ADD;
    case (opcode)
      OP_R: alu_controls = {funct7_5, funct3};
      // bit 30 is part of the immediate except for the shift-right pair
      OP_I: alu_controls = {funct7_5 & (funct3 == 3'b101), funct3};
      OP_B: alu_controls = {1'b0, funct3};
      default: alu_controls = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/mem/write-back sequencing.
// Optional ILLEGAL_INSTR_TRAP_EN: unknown opcodes enter a sticky TRAP state.
//
// state   | meaning
// FETCH   | imem_req high, wait for imem_ready, load IR
// DECODE  | selects settle from the latched instruction
// EXECUTE | retire ALU/branch/jump, or proceed to MEM for load/store
// MEM     | dmem_req held until dmem_ready
// WB      | load data written back to the register file
// TRAP    | illegal instruction, halted until reset
module multicycle_ctrl
  import rv32i_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_code,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        ir_en,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [2:0]  dmem_size,
  input  logic        dmem_ready,
  output logic        pc_en,
  output logic [3:0]  alu_controls,
  output logic        reg_wr_en,
  output logic        aluSrcMux_sel,
  output logic [2:0]  RegWdataSel,
  output logic        Branch,
  output logic        jal,
  output logic        jalr,
  output logic [31:0] instret,
  output logic        halted
);

  logic [2:0]   state_q, state_d;
  logic [31:0]  instret_q;
  logic [3:0]   dec_alu;
  logic         sel_valid;
  logic         unused_instr;
  instr_class_e iclass;

  assign iclass       = classify(instr_code[6:0]);
  assign unused_instr = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};

  alu_decoder u_alu_decoder (
    .opcode       (instr_code[6:0]),
    .funct3       (instr_code[14:12]),
    .funct7_5     (instr_code[30]),
    .alu_controls (dec_alu)
  );

  // Selects are live from DECODE to the end of the instruction, never in FETCH.
  assign sel_valid = reset_n && ((state_q == ST_DECODE) || (state_q == ST_EXECUTE) ||
                                 (state_q == ST_MEM) || (state_q == ST_WB));

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_en     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_en     = 1'b0;
    reg_wr_en = 1'b0;
    if (reset_n) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_en   = 1'b1;
            state_d = ST_DECODE;
          end
        end
        ST_DECODE: state_d = ST_EXECUTE;
        ST_EXECUTE: begin
          case (iclass)
            IC_ALU_R, IC_ALU_I, IC_LUI, IC_AUIPC, IC_JAL, IC_JALR: begin
              reg_wr_en = 1'b1;
              pc_en     = 1'b1;
              state_d   = ST_FETCH;
            end
            IC_BRANCH: begin
              pc_en   = 1'b1;
              state_d = ST_FETCH;
            end
            IC_LOAD, IC_STORE: state_d = ST_MEM;
            default: begin
`ifdef ILLEGAL_INSTR_TRAP_EN
              state_d = ST_TRAP;
`else
              pc_en   = 1'b1;
              state_d = ST_FETCH;
`endif
            end
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (iclass == IC_STORE);
          if (dmem_ready) begin
            if (iclass == IC_STORE) begin
              pc_en   = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_wr_en = 1'b1;
          pc_en     = 1'b1;
          state_d   = ST_FETCH;
        end
`ifdef ILLEGAL_INSTR_TRAP_EN
        ST_TRAP: state_d = ST_TRAP;
`endif
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_comb begin
    alu_controls  = ALU_ADD;
    aluSrcMux_sel = 1'b0;
    RegWdataSel   = WSEL_ALU;
    Branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    dmem_size     = 3'b000;
    if (sel_valid) begin
      alu_controls = dec_alu;
      case (iclass)
        IC_ALU_I:  aluSrcMux_sel = 1'b1;
        IC_LOAD: begin
          aluSrcMux_sel = 1'b1;
          RegWdataSel   = WSEL_DMEM;
          dmem_size     = instr_code[14:12];
        end
        IC_STORE: begin
          aluSrcMux_sel = 1'b1;
          dmem_size     = instr_code[14:12];
        end
        IC_BRANCH: Branch = 1'b1;
        IC_LUI:    RegWdataSel = WSEL_IMM;
        IC_AUIPC:  RegWdataSel = WSEL_PCIMM;
        IC_JAL: begin
          jal         = 1'b1;
          RegWdataSel = WSEL_PC4;
        end
        IC_JALR: begin
          jal           = 1'b1;
          jalr          = 1'b1;
          aluSrcMux_sel = 1'b1;
          RegWdataSel   = WSEL_PC4;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (pc_en) instret_q <= instret_q + 32'd1;
    end
  end

  assign instret = instret_q;

`ifdef ILLEGAL_INSTR_TRAP_EN
  assign halted = reset_n && (state_q == ST_TRAP);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (honours ILLEGAL_INSTR_TRAP_EN).
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, imem_ready, dmem_ready;
  logic [31:0] instr_code;
  logic        imem_req, ir_en, dmem_req, dmem_we, pc_en, reg_wr_en;
  logic        aluSrcMux_sel, Branch, jal, jalr, halted;
  logic [2:0]  dmem_size, RegWdataSel;
  logic [3:0]  alu_controls;
  logic [31:0] instret;

  int errs = 0;
  int checks = 0;
  int exp_instret = 0;

  int n_cyc, n_dreq, n_we, n_wr, n_pc, n_both, n_ir, n_fetch_bad;
  logic [3:0] r_alu;
  logic [2:0] r_sel, r_size;
  logic       r_src, r_br, r_jal, r_jalr;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .instr_code(instr_code),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_en(ir_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
    .dmem_ready(dmem_ready), .pc_en(pc_en), .alu_controls(alu_controls),
    .reg_wr_en(reg_wr_en), .aluSrcMux_sel(aluSrcMux_sel),
    .RegWdataSel(RegWdataSel), .Branch(Branch), .jal(jal), .jalr(jalr),
    .instret(instret), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction from FETCH until its pc_en cycle, answering each
  // request after the given number of wait cycles, and records what it saw.
  task automatic run_instr(input logic [31:0] ins, input int iwait, input int dwait);
    int  ireq = 0;
    int  dreq = 0;
    bit  done = 0;
    n_cyc = 0; n_dreq = 0; n_we = 0; n_wr = 0; n_pc = 0; n_both = 0; n_ir = 0;
    n_fetch_bad = 0;
    r_alu = 'x; r_sel = 'x; r_size = 'x; r_src = 'x; r_br = 'x; r_jal = 'x; r_jalr = 'x;
    instr_code = ins;
    for (int c = 0; c < 40 && !done; c++) begin
      if (imem_req) ireq++;
      if (dmem_req) dreq++;
      imem_ready = imem_req && (ireq > iwait);
      dmem_ready = dmem_req && (dreq > dwait);
      #1;
      n_cyc++;
      if (dmem_req) begin n_dreq++; r_size = dmem_size; end
      if (dmem_we) n_we++;
      if (reg_wr_en) begin n_wr++; r_sel = RegWdataSel; end
      if (ir_en) n_ir++;
      if (imem_req && (pc_en || reg_wr_en || dmem_req || dmem_we || aluSrcMux_sel ||
                       Branch || jal || jalr || alu_controls != 4'd0 || RegWdataSel != 3'd0))
        n_fetch_bad++;
      if (pc_en) begin
        n_pc++;
        done   = 1;
        r_alu  = alu_controls;
        r_src  = aluSrcMux_sel;
        r_br   = Branch;
        r_jal  = jal;
        r_jalr = jalr;
        if (reg_wr_en) n_both++;
      end
      @(posedge clk);
      #1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic verify(input string tag, input int cyc, input int dreq, input int we, input int wr);
    check({tag, " retired"}, 32'(n_pc), 32'd1);
    check({tag, " cycles"}, 32'(n_cyc), 32'(cyc));
    check({tag, " dmem_req cycles"}, 32'(n_dreq), 32'(dreq));
    check({tag, " dmem_we cycles"}, 32'(n_we), 32'(we));
    check({tag, " reg_wr cycles"}, 32'(n_wr), 32'(wr));
    check({tag, " wr+pc same cycle"}, 32'(n_both), 32'(wr));
    check({tag, " ir_en cycles"}, 32'(n_ir), 32'd1);
    check({tag, " quiet fetch"}, 32'(n_fetch_bad), 32'd0);
    exp_instret++;
    check({tag, " instret"}, instret, 32'(exp_instret));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    instr_code = 32'd0;
    repeat (3) tick();
    check("reset imem_req", 32'(imem_req), 32'd0);
    check("reset instret", instret, 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    reset_n = 1'b1;
    #1;
    check("first imem_req", 32'(imem_req), 32'd1);

    run_instr(32'h002081B3, 0, 0);
    verify("add", 3, 0, 0, 1);
    check("add alu", 32'(r_alu), 32'h0);
    check("add wsel", 32'(r_sel), 32'd0);
    check("add src", 32'(r_src), 32'd0);

    run_instr(32'h00402283, 0, 2);
    verify("lw", 7, 3, 0, 1);
    check("lw wsel", 32'(r_sel), 32'd1);
    check("lw size", 32'(r_size), 32'd2);

    run_instr(32'h00502423, 0, 0);
    verify("sw", 4, 1, 1, 0);
    check("sw alu", 32'(r_alu), 32'h0);
    check("sw src", 32'(r_src), 32'd1);
    check("sw size", 32'(r_size), 32'd2);

    run_instr(32'h4032D313, 1, 0);
    verify("srai", 4, 0, 0, 1);
    check("srai alu", 32'(r_alu), 32'hD);
    check("srai src", 32'(r_src), 32'd1);

    run_instr(32'h000100E7, 0, 0);
    verify("jalr", 3, 0, 0, 1);
    check("jalr jal", 32'(r_jal), 32'd1);
    check("jalr jalr", 32'(r_jalr), 32'd1);
    check("jalr wsel", 32'(r_sel), 32'd4);

    run_instr(32'h000000EF, 0, 0);
    verify("jal", 3, 0, 0, 1);
    check("jal jal", 32'(r_jal), 32'd1);
    check("jal jalr", 32'(r_jalr), 32'd0);
    check("jal wsel", 32'(r_sel), 32'd4);

    run_instr(32'h00209063, 0, 0);
    verify("bne", 3, 0, 0, 0);
    check("bne alu", 32'(r_alu), 32'h1);
    check("bne branch", 32'(r_br), 32'd1);

    run_instr(32'h402081B3, 0, 0);
    verify("sub", 3, 0, 0, 1);
    check("sub alu", 32'(r_alu), 32'h8);

    run_instr(32'hC0000093, 0, 0);
    verify("addi neg", 3, 0, 0, 1);
    check("addi alu", 32'(r_alu), 32'h0);
    check("addi src", 32'(r_src), 32'd1);

    run_instr(32'h000012B7, 0, 0);
    verify("lui", 3, 0, 0, 1);
    check("lui wsel", 32'(r_sel), 32'd2);

    run_instr(32'h00001297, 0, 0);
    verify("auipc", 3, 0, 0, 1);
    check("auipc wsel", 32'(r_sel), 32'd3);

`ifdef ILLEGAL_INSTR_TRAP_EN
    begin
      int stray = 0;
      instr_code = 32'h0000007F;
      imem_ready = 1'b1;
      #1;
      check("ill ir_en", 32'(ir_en), 32'd1);
      tick();
      imem_ready = 1'b0;
      tick();
      check("ill exec pc_en", 32'(pc_en), 32'd0);
      tick();
      check("ill halted", 32'(halted), 32'd1);
      imem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (imem_req || pc_en || reg_wr_en || dmem_req || halted !== 1'b1) stray++;
        tick();
      end
      imem_ready = 1'b0;
      check("trap quiet", 32'(stray), 32'd0);
      check("trap instret", instret, 32'(exp_instret));
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      #1;
      exp_instret = 0;
      check("trap cleared", 32'(halted), 32'd0);
      check("trap refetch", 32'(imem_req), 32'd1);
    end
`else
    run_instr(32'h0000007F, 0, 0);
    verify("illegal nop", 3, 0, 0, 0);
`endif

    instr_code = 32'h00402283;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    check("mid dmem_req", 32'(dmem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst drops dmem_req", 32'(dmem_req), 32'd0);
    check("rst imem_req low", 32'(imem_req), 32'd0);
    check("rst clears instret", instret, 32'd0);
    exp_instret = 0;
    tick();
    reset_n = 1'b1;
    #1;
    check("release imem_req", 32'(imem_req), 32'd1);

    run_instr(32'h002081B3, 0, 0);
    verify("add after rst", 3, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
